// File: rtl/apb_irq_ctrl.sv
// APB slave that turns the IRQ arbiter's select/valid into a CPU interrupt and
// runs the ack handshake (ack pulse, then wait for the arbiter to drop its request).
module apb_irq_ctrl #(
  parameter int unsigned ACK_HOLD    = 4,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_psel,
  input  logic        i_penable,
  input  logic        i_pwrite,
  input  logic [7:0]  i_paddr,
  input  logic [31:0] i_pwdata,
  output logic [31:0] o_prdata,
  output logic        o_pready,
  output logic        o_pslverr,
  input  logic [31:0] i_irq_sel,
  input  logic        i_irq_en,
  output logic [31:0] o_irq_ack,
  output logic        o_cpu_irq
);

  localparam int unsigned TW = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_WAIT_CLR = 2'd2
  } state_e;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  state_e         state_q, state_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [7:0]     src_mask_q, src_mask_d;
  logic           glb_en_q, glb_en_d;
  logic           ack_bit_q, ack_bit_d;
  logic [7:0]     ack_id_q, ack_id_d;
  logic           ack_err_q, ack_err_d;
  logic [15:0]    irq_cnt_q, irq_cnt_d;
  logic           irq_en_dly_q;
  logic           cpu_irq_q, cpu_irq_d;
  logic [31:0]    prdata_q, prdata_d;

  logic           apb_wr_s, rd_setup_s, ctrl_wr_s, ack_wr_s, cnt_wr_s;
  logic           ack_ok_s, timeout_s, irq_rise_s;
  logic [1:0]     state_code_s;
  logic [31:0]    rdata_s;
  logic           unused_s;

  assign apb_wr_s     = i_psel & i_penable & i_pwrite;
  assign rd_setup_s   = i_psel & ~i_penable & ~i_pwrite;
  assign ctrl_wr_s    = apb_wr_s & (i_paddr[3:2] == 2'd0);
  assign ack_wr_s     = apb_wr_s & (i_paddr[3:2] == 2'd2);
  assign cnt_wr_s     = apb_wr_s & (i_paddr[3:2] == 2'd3);
  assign ack_ok_s     = (state_q == ST_IDLE) & i_irq_en & is_onehot8(i_pwdata[7:0]) &
                        (i_pwdata[7:0] == i_irq_sel[7:0]);
  assign irq_rise_s   = i_irq_en & ~irq_en_dly_q;
  assign state_code_s = state_q;
  assign unused_s     = ^{i_paddr[7:4], i_paddr[1:0], i_pwdata[31:9], i_irq_sel[31:8]};

  assign o_pready  = 1'b1;
  assign o_pslverr = ack_wr_s & ~ack_ok_s;
  assign o_prdata  = prdata_q;
  assign o_irq_ack = {15'd0, src_mask_q, ack_bit_q, ack_id_q};
  assign o_cpu_irq = cpu_irq_q;

  // Handshake FSM: timer restarts on every state entry and bounds both ack hold and wait.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    ack_bit_d = ack_bit_q;
    ack_id_d  = ack_id_q;
    timeout_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ack_wr_s && ack_ok_s) begin
          state_d   = ST_ASSERT;
          tmr_d     = '0;
          ack_bit_d = 1'b1;
          ack_id_d  = i_pwdata[7:0];
        end else begin
          tmr_d = '0;
        end
      end
      ST_ASSERT: begin
        if (tmr_q == TW'(ACK_HOLD - 1)) begin
          state_d   = ST_WAIT_CLR;
          tmr_d     = '0;
          ack_bit_d = 1'b0;
          ack_id_d  = 8'd0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_WAIT_CLR: begin
        if (!i_irq_en) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          tmr_d     = '0;
          timeout_s = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tmr_d     = '0;
        ack_bit_d = 1'b0;
        ack_id_d  = 8'd0;
      end
    endcase
  end

  // Register file next-state, counter (clear beats increment) and read-data capture.
  always_comb begin
    src_mask_d = ctrl_wr_s ? i_pwdata[7:0] : src_mask_q;
    glb_en_d   = ctrl_wr_s ? i_pwdata[8] : glb_en_q;
    if (cnt_wr_s) begin
      ack_err_d = 1'b0;
    end else if (timeout_s) begin
      ack_err_d = 1'b1;
    end else begin
      ack_err_d = ack_err_q;
    end
    if (cnt_wr_s) begin
      irq_cnt_d = 16'd0;
    end else if (irq_rise_s && (irq_cnt_q != 16'hFFFF)) begin
      irq_cnt_d = irq_cnt_q + 16'd1;
    end else begin
      irq_cnt_d = irq_cnt_q;
    end
    cpu_irq_d = glb_en_q & i_irq_en & (|(i_irq_sel[7:0] & src_mask_q)) & (state_q == ST_IDLE);
    case (i_paddr[3:2])
      2'd0:    rdata_s = {23'd0, glb_en_q, src_mask_q};
      2'd1:    rdata_s = {20'd0, state_code_s, ack_err_q, i_irq_en, i_irq_sel[7:0]};
      2'd2:    rdata_s = 32'd0;
      2'd3:    rdata_s = {16'd0, irq_cnt_q};
      default: rdata_s = 32'd0;
    endcase
    prdata_d = rd_setup_s ? rdata_s : prdata_q;
  end

  // State and register storage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      src_mask_q   <= 8'd0;
      glb_en_q     <= 1'b0;
      ack_bit_q    <= 1'b0;
      ack_id_q     <= 8'd0;
      ack_err_q    <= 1'b0;
      irq_cnt_q    <= 16'd0;
      irq_en_dly_q <= 1'b0;
      cpu_irq_q    <= 1'b0;
      prdata_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      src_mask_q   <= src_mask_d;
      glb_en_q     <= glb_en_d;
      ack_bit_q    <= ack_bit_d;
      ack_id_q     <= ack_id_d;
      ack_err_q    <= ack_err_d;
      irq_cnt_q    <= irq_cnt_d;
      irq_en_dly_q <= i_irq_en;
      cpu_irq_q    <= cpu_irq_d;
      prdata_q     <= prdata_d;
    end
  end

endmodule

// File: doc/apb_irq_ctrl.md
Name: apb_irq_ctrl

Overview:
- CPU-facing APB slave that consumes the IRQ arbiter's o_irq_sel/o_irq_en and produces the 32-bit ack/enable word the arbiter reads on its i_irq_ack input.
- Drives the CPU interrupt line.
- Exposes enable, status and counter registers.
- Runs the acknowledge handshake: ack pulse, then wait for the arbiter to drop its request.

Parameters:
- ACK_HOLD, 4: cycles the ack word holds bit8=1; legal range 2..255.
- ACK_TIMEOUT, 64: cycles allowed in WAIT_CLR for i_irq_en to fall; must be ≥ 8.

Ports:
- i_clk  in  1  system clock (same domain as arbiter)
- i_rst  in  1  asynchronous active-high reset
- i_psel  in  1  APB select
- i_penable  in  1  APB enable
- i_pwrite  in  1  APB write
- i_paddr  in  8  APB byte address; only [3:2] decoded
- i_pwdata  in  32  APB write data
- o_prdata  out  32  APB read data
- o_pready  out  1  APB ready; constant 1, zero wait-state
- o_pslverr  out  1  APB error
- i_irq_sel  in  32  arbiter one-hot source select; only [7:0] used
- i_irq_en  in  1  arbiter request-valid
- o_irq_ack  out  32  ack/enable word to arbiter
- o_cpu_irq  out  1  level interrupt to CPU

Behaviour:
- Reset (i_rst=1, asynchronous): all registers 0, state IDLE. Resulting outputs: o_irq_ack=0, o_cpu_irq=0, o_prdata=0, o_pslverr=0.
- Register map, offset by i_paddr[3:2]:
  - 0x0 CTRL, RW: [7:0] src_mask, [8] glb_en; other bits read 0.
  - 0x4 STATUS, RO: [7:0] i_irq_sel[7:0], [8] i_irq_en, [9] ack_err (sticky), [11:10] state code.
  - 0x8 ACK, WO: reads return 0.
  - 0xC CNT, RO: [15:0] irq_cnt. A write of any value clears irq_cnt and ack_err.
- APB timing:
  - Write commits on the cycle where psel & penable & pwrite.
  - o_prdata is registered on the setup cycle (psel & !penable & !pwrite) and is valid during the access cycle.
  - o_pslverr is combinational, asserted only in the access cycle.
- ack word format: {15'b0, src_mask[7:0], ack_bit, ack_id[7:0]}.
  - IDLE: ack_bit=0, ack_id=0. The idle word continuously programs the arbiter's enable mask.
  - A CTRL write changes src_mask in o_irq_ack on the next cycle.
- ACK write acceptance:
  - Accepted only if state==IDLE, i_irq_en==1, pwdata[7:0] is one-hot, and pwdata[7:0]==i_irq_sel[7:0].
  - Otherwise the write is ignored and o_pslverr=1 for that access cycle.
- FSM, registered, state codes IDLE=0, ASSERT=1, WAIT_CLR=2:
  - IDLE → ASSERT on an accepted ACK write. Latch ack_id=pwdata[7:0]; ack_bit=1 from the next cycle.
  - ASSERT: hold ack_bit=1 and ack_id for exactly ACK_HOLD cycles. Then ack_bit=0, ack_id=0, go to WAIT_CLR.
  - WAIT_CLR → IDLE when i_irq_en==0.
  - WAIT_CLR timeout: if ACK_TIMEOUT cycles pass with i_irq_en still 1, set ack_err=1 and go to IDLE.
  - Timeout counter: 8-bit minimum, clears on every state entry.
- o_cpu_irq:
  - Registered, one-cycle latency.
  - Value = glb_en & i_irq_en & |(i_irq_sel[7:0] & src_mask) & (state==IDLE).
  - Drops the cycle after entering ASSERT.
- irq_cnt:
  - +1 on each i_irq_en rising edge, detected with a one-cycle delay register.
  - Saturates at 0xFFFF.
  - If a CNT write and an increment occur in the same cycle, the clear wins.
- Simultaneous events:
  - CTRL write during ASSERT updates src_mask bits of o_irq_ack immediately; ack_bit and ack_id are unaffected.
  - ack_err set by timeout and a CNT clear in the same cycle: the clear wins.
- Reset mid-handshake: immediate return to IDLE. o_irq_ack=0, which disables all arbiter sources until CTRL is rewritten.

Test Plan:
- Reset, then write CTRL=0x1FF → o_irq_ack=0x0001FE00 one cycle later; o_cpu_irq stays 0 with i_irq_en=0.
- CTRL=0x1FF, i_irq_sel=0x02, i_irq_en=1 → o_cpu_irq=1 next cycle; STATUS reads 0x102; CNT=1.
- Accepted ACK write 0x02:
  - o_irq_ack=0x0001FF02 for exactly 4 cycles, then 0x0001FE00.
  - Drop i_irq_en 3 cycles after the ack starts → return to IDLE; o_cpu_irq=0 throughout.
- ACK write 0x04 while i_irq_sel=0x02, or ACK write while i_irq_en=0 → o_pslverr=1; o_irq_ack unchanged; state stays IDLE.
- Accepted ACK, i_irq_en held 1 → after 4+64 cycles ack_err=1, STATUS[9]=1, state IDLE; CNT write clears ack_err and irq_cnt.
- Assert i_rst during ASSERT → o_irq_ack=0, o_cpu_irq=0 asynchronously; after release, CTRL reads 0.
